// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive sampler: state encoding,
// default oversampling ratio, mid-bit sample offsets and the
// majority-of-three helper.
package uart_rx_pkg;

  // Sampler states (legacy 2-bit encoding)
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START_CHK = 2'd1;
  localparam logic [1:0] ST_DATA      = 2'd2;

  // OS_TICK pulses per bit period unless overridden
  localparam int OVERSAMPLE_DEFAULT = 16;

  // Samples are taken at M-SAMPLE_OFS_BEFORE, M and M+SAMPLE_OFS_AFTER,
  // where M is the bit-centre phase OVERSAMPLE/2
  localparam int SAMPLE_OFS_BEFORE = 1;
  localparam int SAMPLE_OFS_AFTER  = 1;

  // Majority of three samples
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Generic multi-flop synchroniser for an asynchronous single-bit input.
// Every stage resets to 1 (idle level of UART-style lines), so it can be
// reused for RX, CTS and similar active-low-asserted inputs.
module uart_bit_sync
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the async input through the flop chain; stage 0 is the capture flop
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], D};
    end
  end

  assign Q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises RX_IN, qualifies the start bit and
// majority-votes three mid-bit oversamples per bit.
//
// Optional build macro: UART_RX_NOISE_FLAG_EN adds the NOISE_ERR output,
// which pulses alongside a vote whose three samples disagree.
//
// Output strobe contract: BIT_TICK, START_DET, FALSE_START (and NOISE_ERR)
// are single-CLK pulses with no back-pressure; the consumer must take them
// in the cycle they are high. SAMPLED_BIT is valid in the BIT_TICK cycle
// and held until the next BIT_TICK, or forced to 1 while EN is low.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic RX_IN,
  input  logic OS_TICK,
  input  logic EN,
  output logic SAMPLED_BIT,
  output logic BIT_TICK,
  output logic START_DET,
  output logic FALSE_START,
`ifdef UART_RX_NOISE_FLAG_EN
  output logic NOISE_ERR,
`endif
  output logic BUSY
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_FIRST = PW'(OVERSAMPLE / 2 - SAMPLE_OFS_BEFORE);
  localparam logic [PW-1:0] PH_MID   = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE / 2 + SAMPLE_OFS_AFTER);
  localparam logic [PW-1:0] PH_MAX   = PW'(OVERSAMPLE - 1);

  logic          rx_s;
  logic [1:0]    state;
  logic [PW-1:0] phase;
  logic [PW-1:0] phase_next;
  logic [1:0]    vote_q;       // [0] = early sample, [1] = centre sample
  logic          vote;
  logic          vote_now;
  logic          sampled_bit_q;
  logic          bit_tick_q;
  logic          start_det_q;
  logic          false_start_q;

  uart_bit_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .CLK(CLK),
    .RST(RST),
    .D  (RX_IN),
    .Q  (rx_s)
  );

  // Third sample is the live synchronised line on the final sample tick
  assign vote       = maj3(vote_q[0], vote_q[1], rx_s);
  assign vote_now   = OS_TICK && (state != ST_IDLE) && (phase == PH_LAST);
  assign phase_next = (phase == PH_MAX) ? '0 : phase + 1'b1;

  // State and phase: the detecting tick counts as phase 0, so START_CHK
  // begins at phase 1 and the bit grid stays aligned to the start edge
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      state <= ST_IDLE;
      phase <= '0;
    end else if (OS_TICK) begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START_CHK;
            phase <= PW'(1);
          end
        end
        ST_START_CHK: begin
          if (vote_now && vote) begin
            state <= ST_IDLE;
            phase <= '0;
          end else begin
            phase <= phase_next;
            if (phase == PH_MAX) begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          phase <= phase_next;
        end
        default: begin
          state <= ST_IDLE;
          phase <= '0;
        end
      endcase
    end
  end

  // Capture the early and centre samples of the current bit
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      vote_q <= '0;
    end else if (OS_TICK && (state != ST_IDLE)) begin
      if (phase == PH_FIRST) begin
        vote_q[0] <= rx_s;
      end
      if (phase == PH_MID) begin
        vote_q[1] <= rx_s;
      end
    end
  end

  // Registered vote results: one-cycle pulses plus the held data bit
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      sampled_bit_q <= 1'b1;
      bit_tick_q    <= 1'b0;
      start_det_q   <= 1'b0;
      false_start_q <= 1'b0;
    end else begin
      bit_tick_q    <= 1'b0;
      start_det_q   <= 1'b0;
      false_start_q <= 1'b0;
      if (vote_now) begin
        case (state)
          ST_START_CHK: begin
            if (vote) begin
              false_start_q <= 1'b1;
            end else begin
              start_det_q <= 1'b1;
            end
          end
          ST_DATA: begin
            bit_tick_q    <= 1'b1;
            sampled_bit_q <= vote;
          end
          default: begin
            bit_tick_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef UART_RX_NOISE_FLAG_EN
  logic noise_q;
  logic unanimous;

  assign unanimous = (vote_q[0] == vote_q[1]) && (vote_q[1] == rx_s);

  // Flag any vote whose three samples disagree, in step with its pulse
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      noise_q <= 1'b0;
    end else begin
      noise_q <= vote_now && !unanimous;
    end
  end

  assign NOISE_ERR = noise_q;
`endif

  assign SAMPLED_BIT = sampled_bit_q;
  assign BIT_TICK    = bit_tick_q;
  assign START_DET   = start_det_q;
  assign FALSE_START = false_start_q;
  assign BUSY        = (state != ST_IDLE);

endmodule
